// File: rtl/svm_sv_classifier.sv
// svm_sv_classifier
//   Captures the support-vector stream (alpha, x_sv, y_sv) from the SVM
//   trainer. After training is done it classifies 9-bit test samples with
//   a linear kernel:
//       score = bias + sum_i y_i * alpha_i * (x_sv_i * x)
//   It returns a +1/-1 label for each sample. The sum is computed one
//   stored support vector per clock cycle.
//
// Optional feature: define SVM_SCORE_OUT_EN to add the `score` output port.
//   `score` holds the final accumulator value from the most recent result.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   sv_valid           trainer word valid (used only in LOAD)
//   alpha_in, x_sv_in  unsigned 9-bit multiplier and support-vector sample
//   y_sv_in            signed 2-bit label; only +1 and -1 are stored
//   train_done         moves LOAD -> READY
//   sv_clear           synchronous flush; returns to LOAD
//   bias               signed decision offset, sampled when a test is accepted
//   test_valid/test_x  test sample handshake (valid) and data
//   test_ready         high in READY
//   result_valid       one-cycle pulse when the label is valid
//   result_label       +1 (2'b01) or -1 (2'b11); held until the next result
//   sv_count           number of stored support-vector entries
//   sv_overflow        sticky; set when a word is dropped because the buffer is full
//   score              (SVM_SCORE_OUT_EN only) final accumulator of the last result
module svm_sv_classifier #(
    parameter int MAX_SV = 64,
    parameter int CNT_W  = 7,
    parameter int ACC_W  = 36
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    sv_valid,
    input  logic [8:0]              alpha_in,
    input  logic [8:0]              x_sv_in,
    input  logic [1:0]              y_sv_in,
    input  logic                    train_done,
    input  logic                    sv_clear,
    input  logic signed [ACC_W-1:0] bias,
    input  logic                    test_valid,
    input  logic [8:0]              test_x,
    output logic                    test_ready,
    output logic                    result_valid,
    output logic [1:0]              result_label,
    output logic [CNT_W-1:0]        sv_count,
    output logic                    sv_overflow
`ifdef SVM_SCORE_OUT_EN
   ,output logic signed [ACC_W-1:0] score
`endif
);

    localparam int IDX_W  = (MAX_SV > 1) ? $clog2(MAX_SV) : 1;
    localparam int PROD_W = 27;

    typedef enum logic [1:0] {
        S_LOAD,
        S_READY,
        S_ACCUM,
        S_RESULT
    } state_t;

    state_t r_state, w_state_next;

    // Support-vector buffer. y is stored as one bit: 1 means -1.
    logic [8:0] r_alpha [MAX_SV];
    logic [8:0] r_xsv   [MAX_SV];
    logic       r_yneg  [MAX_SV];

    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        r_idx;
    logic                    r_ovf;
    logic [8:0]              r_x;
    logic signed [ACC_W-1:0] r_acc;
    logic [1:0]              r_label;

    logic                    w_y_ok;
    logic                    w_full;
    logic                    w_sv_word;
    logic                    w_sv_take;
    logic                    w_sv_drop;
    logic                    w_accept;
    logic                    w_last;
    logic [IDX_W-1:0]        w_rd_idx;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [PROD_W-1:0]       w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_step;
    logic signed [ACC_W-1:0] w_acc_final;

    assign w_y_ok    = (y_sv_in == 2'b01) || (y_sv_in == 2'b11);
    assign w_full    = (r_count >= CNT_W'(MAX_SV));
    assign w_sv_word = (r_state == S_LOAD) && sv_valid && (alpha_in != '0) && w_y_ok && !sv_clear;
    assign w_sv_take = w_sv_word && !w_full;
    assign w_sv_drop = w_sv_word && w_full;
    assign w_accept  = (r_state == S_READY) && test_valid;
    assign w_last    = (r_idx == r_count - CNT_W'(1));
    assign w_rd_idx  = r_idx[IDX_W-1:0];
    assign w_wr_idx  = r_count[IDX_W-1:0];

    // 9b*9b*9b fits exactly in 27 bits, so the unsigned product never truncates.
    assign w_prod     = PROD_W'(r_alpha[w_rd_idx]) * PROD_W'(r_xsv[w_rd_idx]) * PROD_W'(r_x);
    assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, w_prod};
    assign w_acc_step = r_yneg[w_rd_idx] ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);

    // Value of the final score at the edge that enters RESULT. With an empty
    // buffer that edge is the accept edge, so the score is bias itself.
    assign w_acc_final = (r_state == S_READY) ? bias : w_acc_step;

    assign test_ready   = (r_state == S_READY);
    assign result_valid = (r_state == S_RESULT);
    assign result_label = r_label;
    assign sv_count     = r_count;
    assign sv_overflow  = r_ovf;

    always_comb begin
        w_state_next = r_state;
        if (sv_clear) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:   if (train_done) w_state_next = S_READY;
                S_READY:  if (test_valid) w_state_next = (r_count == '0) ? S_RESULT : S_ACCUM;
                S_ACCUM:  if (w_last) w_state_next = S_RESULT;
                S_RESULT: w_state_next = S_READY;
                default:  w_state_next = S_LOAD;
            endcase
        end
    end

    // Buffer storage is not reset; entries at or above sv_count are never read.
    always_ff @(posedge clk) begin
        if (w_sv_take) begin
            r_alpha[w_wr_idx] <= alpha_in;
            r_xsv[w_wr_idx]   <= x_sv_in;
            r_yneg[w_wr_idx]  <= y_sv_in[1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_x     <= '0;
            r_acc   <= '0;
            r_label <= '0;
        end else begin
            r_state <= w_state_next;
            if (sv_clear) begin
                r_count <= '0;
                r_idx   <= '0;
                r_ovf   <= 1'b0;
                r_acc   <= '0;
            end else begin
                if (w_sv_take) r_count <= r_count + CNT_W'(1);
                if (w_sv_drop) r_ovf   <= 1'b1;
                if (w_accept) begin
                    r_x   <= test_x;
                    r_acc <= bias;
                    r_idx <= '0;
                end else if (r_state == S_ACCUM) begin
                    r_acc <= w_acc_step;
                    r_idx <= r_idx + CNT_W'(1);
                end
                // Register the label at the edge that enters RESULT, so it
                // is already valid while result_valid is high.
                if (w_state_next == S_RESULT)
                    r_label <= w_acc_final[ACC_W-1] ? 2'b11 : 2'b01;
            end
        end
    end

`ifdef SVM_SCORE_OUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            score <= '0;
        else if (sv_clear)
            score <= '0;
        else if (w_state_next == S_RESULT)
            score <= w_acc_final;
    end
`else
    // Without SVM_SCORE_OUT_EN the final score is seen only through result_label.
`endif

endmodule

// File: doc/svm_sv_classifier.md
Name: svm_sv_classifier

Overview:
- Downstream consumer of the SVM trainer. Captures the support-vector stream (alpha, x_sv, y_sv) until training completes.
- Then classifies 9-bit test samples with a linear-kernel decision function: score = bias + sum over i of y_i * alpha_i * (x_sv_i * x).
- Produces a +1/-1 label per sample through a valid/ready input handshake and a one-cycle result pulse.

Parameters:
- MAX_SV, 64, depth of the support-vector buffer (entries).
- CNT_W, 7, width of sv_count; must hold 0..MAX_SV.
- ACC_W, 36, signed accumulator and bias width; must be >= 28+clog2(MAX_SV).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sv_valid  in  1  trainer SV word valid this cycle
- alpha_in  in  9  unsigned Lagrange multiplier from trainer
- x_sv_in  in  9  unsigned support-vector sample
- y_sv_in  in  2  signed label, +1 or -1
- train_done  in  1  trainer DONE level
- sv_clear  in  1  synchronous flush of buffer, returns to LOAD
- bias  in  ACC_W  signed decision offset, sampled at test accept
- test_valid  in  1  test sample offered
- test_x  in  9  unsigned test sample
- test_ready  out  1  block can accept a test sample
- result_valid  out  1  one-cycle pulse, label valid
- result_label  out  2  signed +1/-1, held until next result
- sv_count  out  CNT_W  stored SV entries
- sv_overflow  out  1  sticky: SV dropped because buffer full

Behaviour:
- Reset (async, resetn=0): state LOAD, sv_count=0, sv_overflow=0, test_ready=0, result_valid=0, result_label=0, accumulator/index cleared. Buffer contents don't-care.
- States: LOAD, READY, ACCUM, RESULT.
- LOAD: each cycle with sv_valid=1 an entry is written at index sv_count, and sv_count increments, when all of these hold:
  - alpha_in != 0,
  - y_sv_in is +1 or -1,
  - sv_count < MAX_SV.
  - alpha_in==0 or y_sv_in in {0,-2}: word ignored silently.
  - Buffer full: word dropped, sv_overflow set (sticky until reset/sv_clear).
  - train_done=1 moves to READY next cycle. A valid word in the same cycle as train_done is still captured.
- READY: test_ready=1. On test_valid && test_ready:
  - latch test_x,
  - acc <= sign-extended bias,
  - idx <= 0.
  - Go to ACCUM, or directly to RESULT if sv_count==0.
  - test_valid without ready is held by the source; no capture.
- ACCUM: test_ready=0. One entry per cycle:
  - prod = alpha[idx]*(x_sv[idx]*x): unsigned 27 bits, zero-extended to ACC_W.
  - acc += prod if y=+1, acc -= prod if y=-1. Two's-complement wrap, no saturation.
  - idx increments. After entry sv_count-1, go to RESULT.
- RESULT: result_valid=1 for exactly this cycle; result_label = +1 if final acc >= 0, else -1. Next state READY.
- Latency: accept edge at cycle t; result_valid high in cycle t+sv_count+1. Throughput is one sample per sv_count+2 cycles.
- sv_clear=1 (any state, priority over everything except reset): next state LOAD, sv_count=0, sv_overflow=0, result_valid=0. Any in-flight classification is aborted with no result. result_label keeps its value.
- train_done is ignored outside LOAD. sv_valid is ignored outside LOAD.
- Reset asserted mid-ACCUM: immediate clear, no result pulse.

Optional Feature:
- Macro SVM_SCORE_OUT_EN.
- Defined: adds output port score (ACC_W, signed).
  - Reset 0; loaded with the final acc in the RESULT cycle; held until the next RESULT.
  - Cleared to 0 by sv_clear.
- Undefined: port absent, no extra registers; label behaviour identical.

Test Plan:
- Load (2,10,+1),(1,20,-1),(3,5,+1); train_done; bias=0; test_x=4 -> sv_count=3; score 60; result_valid exactly 4 cycles after accept edge; label +1.
- Same SVs, bias=-61 -> score -1, label -1. Bias=-60 -> score 0, label +1.
- Stream 5 words with alpha_in=0 on word 2 -> sv_count=4, sv_overflow=0. With MAX_SV=2 and 4 valid words -> sv_count=2, sv_overflow=1.
- train_done with no SVs loaded, bias=-1, test_x=7 -> result_valid in cycle after accept, label -1. Bias=5 -> label +1.
- Assert resetn=0 during ACCUM of a 3-SV classification -> no result_valid; test_ready=0; sv_count=0; state LOAD. Pulse sv_clear in ACCUM -> same, result_label retains prior value.
- Back-to-back test_valid held high with 3 SVs -> accepts every 5 cycles; test_ready low during ACCUM/RESULT; labels match the reference model for x=4, 0, 511.
